// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin scheduler sharing one pipelined ALU among requesters; define ALU_ARB_FIXED_PRIO_EN for fixed priority
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ALU_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [3*NUM_REQ-1:0]    req_aluop,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [31:0]             resp_f,
  output logic                    resp_err,
  output logic                    alu_valid_i,
  output logic [2:0]              alu_aluop,
  output logic [31:0]             alu_a,
  output logic [31:0]             alu_b,
  input  logic [31:0]             alu_f,
  input  logic                    alu_valid_o
);
  localparam int PW = $clog2(NUM_REQ);
  typedef struct packed {
    logic          vld;
    logic [PW-1:0] id;
    logic          err;
  } tag_t;
  tag_t [ALU_LAT-1:0] tag_q, tag_d;
  logic [NUM_REQ-1:0] busy_q, busy_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] elig;
  logic [PW-1:0]      gnt;
  logic               gnt_vld;
  logic [2:0]         gop;
  tag_t               last;
  logic               unused_valid_o;
  assign unused_valid_o = alu_valid_o;
  // response from the last tag stage, then eligibility and round-robin grant
  always_comb begin
    last = tag_q[ALU_LAT-1];
    resp_valid = '0;
    resp_err = 1'b0;
    resp_f = '0;
    if (last.vld && !rst) begin
      resp_valid[last.id] = 1'b1;
      resp_err = last.err;
      resp_f = last.err ? '0 : alu_f;
    end
    elig = req_valid & (~busy_q | resp_valid);
    gnt_vld = 1'b0;
    gnt = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (elig[idx] && !rst) begin
        gnt_vld = 1'b1;
        gnt = PW'(idx);
      end
    end
    req_ready = '0;
    if (gnt_vld) req_ready[gnt] = 1'b1;
    gop = req_aluop[3*gnt +: 3];
    alu_valid_i = gnt_vld && gop != 3'd7;
    alu_aluop = alu_valid_i ? gop : 3'd0;
    alu_a = alu_valid_i ? req_a[32*gnt +: 32] : 32'd0;
    alu_b = alu_valid_i ? req_b[32*gnt +: 32] : 32'd0;
  end
  // next state: busy flags, pointer advance and tag pipe shift
  always_comb begin
    tag_d[0] = {gnt_vld, gnt, gnt_vld && gop == 3'd7};
    for (int k = 1; k < ALU_LAT; k++) tag_d[k] = tag_q[k-1];
    busy_d = busy_q & ~resp_valid;
    if (gnt_vld) busy_d[gnt] = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    rr_ptr_d = '0;
`else
    rr_ptr_d = !gnt_vld ? rr_ptr_q : (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + PW'(1);
`endif
  end
  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q <= '0;
      busy_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      tag_q <= tag_d;
      busy_q <= busy_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed checks of alu_arbiter against a queue-based scheduling model
module tb_alu_arbiter;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [11:0]  req_aluop = '0;
  logic [127:0] req_a = '0;
  logic [127:0] req_b = '0;
  logic [3:0]   resp_valid;
  logic [31:0]  resp_f;
  logic         resp_err;
  logic         alu_valid_i;
  logic [2:0]   alu_aluop;
  logic [31:0]  alu_a, alu_b, alu_f;
  logic         alu_valid_o;

  alu_arbiter #(.NUM_REQ(4), .ALU_LAT(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_aluop(req_aluop), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_f(resp_f), .resp_err(resp_err),
    .alu_valid_i(alu_valid_i), .alu_aluop(alu_aluop), .alu_a(alu_a), .alu_b(alu_b),
    .alu_f(alu_f), .alu_valid_o(alu_valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return a + b;
      3'd4: return a - b;
      3'd5: return a << b[4:0];
      3'd6: return a >> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  // two-stage ALU without reset
  logic        s1_v = 1'b0, s2_v = 1'b0;
  logic [31:0] s1_r = '0, s2_r = '0;
  always @(posedge clk) begin
    s1_v <= alu_valid_i;
    s1_r <= alu_fn(alu_aluop, alu_a, alu_b);
    s2_v <= s1_v;
    s2_r <= s1_r;
  end
  assign alu_f = s2_r;
  assign alu_valid_o = s2_v;

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    int          id;
    int          due;
    logic [31:0] f;
    logic        err;
  } ent_t;
  ent_t q[$];
  int   ptr = 0;
  int   cyc = 0;
  logic [3:0]  obs_rdy, obs_rv, last_gnt;
  logic [31:0] obs_f;
  logic        obs_err, obs_avi, obs_avo;

  task automatic tick();
    logic [3:0]  erv, ebusy, eel;
    logic [31:0] ef;
    logic        ee;
    logic [2:0]  op;
    int          g;
    @(negedge clk);
    erv = '0; ebusy = '0; ef = '0; ee = 1'b0;
    foreach (q[k]) begin
      if (q[k].due == cyc) begin
        erv[q[k].id] = 1'b1;
        ef = q[k].f;
        ee = q[k].err;
      end else ebusy[q[k].id] = 1'b1;
    end
    eel = req_valid & ~ebusy;
    g = -1;
    for (int k = 0; k < 4; k++) if (g < 0 && eel[(ptr + k) % 4]) g = (ptr + k) % 4;
    op = (g >= 0) ? req_aluop[3*g +: 3] : 3'd0;
    last_gnt = (g >= 0) ? (4'b1 << g) : 4'b0;
    obs_rdy = req_ready; obs_rv = resp_valid; obs_f = resp_f; obs_err = resp_err;
    obs_avi = alu_valid_i; obs_avo = alu_valid_o;
    chk("req_ready", {28'd0, req_ready}, {28'd0, last_gnt});
    chk("resp_valid", {28'd0, resp_valid}, {28'd0, erv});
    chk("resp_err", {31'd0, resp_err}, {31'd0, ee});
    chk("resp_f", resp_f, ef);
    chk("alu_valid_i", {31'd0, alu_valid_i}, {31'd0, g >= 0 && op != 3'd7});
    chk("alu_aluop", {29'd0, alu_aluop}, (g >= 0 && op != 3'd7) ? {29'd0, op} : 32'd0);
    chk("alu_a", alu_a, (g >= 0 && op != 3'd7) ? req_a[32*g +: 32] : 32'd0);
    chk("alu_b", alu_b, (g >= 0 && op != 3'd7) ? req_b[32*g +: 32] : 32'd0);
    @(posedge clk);
    if (g >= 0) begin
      q.push_back('{g, cyc + 2, (op == 3'd7) ? 32'd0 : alu_fn(op, req_a[32*g +: 32], req_b[32*g +: 32]), op == 3'd7});
`ifdef ALU_ARB_FIXED_PRIO_EN
      ptr = 0;
`else
      ptr = (g + 1) % 4;
`endif
    end
    for (int k = q.size() - 1; k >= 0; k--) if (q[k].due <= cyc) q.delete(k);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    ptr = 0;
    last_gnt = '0;
    @(negedge clk);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {28'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_f", resp_f, 32'd0);
    chk("rst_alu_valid_i", {31'd0, alu_valid_i}, 32'd0);
    @(posedge clk);
    cyc++;
    #1 rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid[i] = v;
    req_aluop[3*i +: 3] = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  initial begin
    do_reset();
    // requester 1 ADD 5+7
    set_req(1, 1'b1, 3'd3, 32'd5, 32'd7);
    tick(); chk("tp1_ready", {28'd0, obs_rdy}, 32'h2);
    set_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
    tick(); tick();
    chk("tp1_rv", {28'd0, obs_rv}, 32'h2);
    chk("tp1_f", obs_f, 32'd12);
    chk("tp1_err", {31'd0, obs_err}, 32'd0);
    // illegal opcode on requester 2
    set_req(2, 1'b1, 3'd7, 32'hdead, 32'hbeef);
    tick(); chk("tp3_avi", {31'd0, obs_avi}, 32'd0);
    set_req(2, 1'b0, 3'd0, 32'd0, 32'd0);
    tick(); tick();
    chk("tp3_rv", {28'd0, obs_rv}, 32'h4);
    chk("tp3_err", {31'd0, obs_err}, 32'd1);
    chk("tp3_f", obs_f, 32'd0);
    // back-to-back on requester 0 with same-cycle reissue
    set_req(0, 1'b1, 3'd5, 32'd1, 32'd31);
    tick();
    set_req(0, 1'b1, 3'd6, 32'h8000_0000, 32'd31);
    tick(); chk("tp4_busy_ready", {28'd0, obs_rdy}, 32'd0);
    tick();
    chk("tp4_rv1", {28'd0, obs_rv}, 32'h1);
    chk("tp4_f1", obs_f, 32'h8000_0000);
    chk("tp4_reissue", {28'd0, obs_rdy}, 32'h1);
    set_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
    tick(); tick();
    chk("tp4_rv2", {28'd0, obs_rv}, 32'h1);
    chk("tp4_f2", obs_f, 32'd1);
    // all requesters held valid
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 3'd0, 32'hff00_ff00 + i, 32'h0ff0_0ff0);
    for (int k = 0; k < 8; k++) begin
      tick();
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk("tp2_order", {28'd0, obs_rdy}, 32'd1 << (k % 2));
`else
      chk("tp2_order", {28'd0, obs_rdy}, 32'd1 << (k % 4));
`endif
    end
    req_valid = '0;
    tick(); tick(); tick();
    // reset with two operations in flight
    set_req(0, 1'b1, 3'd3, 32'd10, 32'd20);
    tick();
    set_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
    set_req(1, 1'b1, 3'd3, 32'd30, 32'd40);
    tick();
    set_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
    do_reset();
    tick();
    chk("tp5_alu_vo", {31'd0, obs_avo}, 32'd1);
    chk("tp5_no_resp", {28'd0, obs_rv}, 32'd0);
    set_req(3, 1'b1, 3'd1, 32'h0f, 32'hf0);
    tick(); chk("tp5_accept", {28'd0, obs_rdy}, 32'h8);
    set_req(3, 1'b0, 3'd0, 32'd0, 32'd0);
    tick(); tick();
    chk("tp5_f", obs_f, 32'hff);
    // random traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      for (int i = 0; i < 4; i++)
        if (!req_valid[i] || last_gnt[i])
          set_req(i, $urandom_range(0, 99) < 60, 3'($urandom_range(0, 7)), $urandom, $urandom);
      tick();
    end
    req_valid = '0;
    tick(); tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and scheduler that shares one two-stage pipelined ALU among `NUM_REQ` requesters. Each requester issues operations over a valid/ready handshake. The block issues at most one operation per cycle into the ALU and tracks every in-flight operation with a tag pipeline. It routes each result back to the requester that issued it as a one-cycle response pulse. It sits between the ALU and its clients, and it is the only agent that drives the ALU inputs.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `ALU_LAT`, 2: cycles from the ALU sampling its inputs to `valid_o`; must match the ALU's fixed latency.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- `req_aluop`  in  3*NUM_REQ  packed opcodes; requester i uses bits [3i+2:3i].
- `req_a`, `req_b`  in  32*NUM_REQ  packed operands; requester i uses bits [32i+31:32i].
- `resp_valid`  out  NUM_REQ  one-hot one-cycle response strobe.
- `resp_f`  out  32  result; meaningful only while any `resp_valid` bit is high.
- `resp_err`  out  1  high with `resp_valid` when the request carried an illegal opcode (3'd7).
- `alu_valid_i`  out  1  drives the ALU's `valid_i`.
- `alu_aluop`  out  3  drives the ALU's `aluop`.
- `alu_a`, `alu_b`  out  32  drive the ALU's `a` and `b`.
- `alu_f`  in  32  the ALU's `f`.
- `alu_valid_o`  in  1  the ALU's `valid_o`; used only for checking.

## Operation
**State**
- `busy[NUM_REQ]`: a per-requester outstanding flag. Each requester has at most one operation in flight.
- `rr_ptr`: the round-robin pointer, `$clog2(NUM_REQ)` bits wide.
- Tag pipe: `ALU_LAT` stages, each holding {vld, id, err}.

**Eligibility and grant**
- Requester i is eligible when `req_valid[i] && (!busy[i] || resp_valid[i])`. The response cycle frees the slot, so a new request may be accepted in the same cycle.
- Grant goes to the first eligible index, searching `rr_ptr`, `rr_ptr+1`, … modulo `NUM_REQ`.
- `req_ready[g]=1` only for the granted index g. Ready depends on valid. A requester must hold its valid, opcode and operands stable until it sees ready.

**On accept of requester g**
- `busy[g]` is set.
- `rr_ptr` becomes `(g+1) mod NUM_REQ`.
- Tag stage 0 loads {1, g, aluop==7}.

**ALU drive (combinational from the grant)**
- For a legal opcode:
  - `alu_valid_i=1`.
  - `alu_aluop`, `alu_a` and `alu_b` come from requester g.
- For an illegal opcode:
  - `alu_valid_i=0`.
  - `alu_aluop=0`, `alu_a=0`, `alu_b=0`.
  - The operation still occupies a tag slot.
- With no grant, all ALU outputs are 0.

**Response**
- When the last tag stage has vld=1:
  - `resp_valid[id]=1` and `busy[id]` clears.
  - `resp_err=err`.
  - `resp_f` is `alu_f`, or 0 when err is set.
- The tag pipe's vld bit is authoritative. `alu_valid_o` never creates or suppresses a response.

**Reset**
- All `busy` flags, `rr_ptr` and every tag vld bit go to 0.
- While `rst` is high, the following outputs are 0: `req_ready`, `resp_valid`, `resp_err`, `resp_f` and `alu_valid_i`.
- The ALU has no reset, so it may still emit `valid_o` after a mid-operation reset. The tag pipe has been cleared, so those ALU outputs are ignored.

## Timing
- The handshake completes at edge E0 of cycle 0, and the ALU samples its inputs at that same edge.
- The response appears in cycle `ALU_LAT`, i.e. cycle 2. The response is combinational from `alu_f` and the tag pipe.
- Peak throughput is one issue per cycle across all requesters. A single requester can issue back-to-back every `ALU_LAT` cycles.
- Simultaneous response and new request for the same requester is legal and is accepted in that cycle.

## Configuration
- Macro `ALU_ARB_FIXED_PRIO_EN`.
  - Defined: fixed priority. The lowest eligible index always wins and `rr_ptr` is unused (held at 0).
  - Undefined: round-robin as described above.

## Test plan
- Reset, then requester 1 sends aluop=3, a=5, b=7 → `req_ready[1]=1` in cycle 0; `resp_valid=4'b0010` and `resp_f=12` in cycle 2; `resp_err=0`.
- All four requesters hold valid continuously with op=0 (AND) → grants in order 0,1,2,3 on consecutive cycles; responses two cycles later in the same order. With `ALU_ARB_FIXED_PRIO_EN` defined, the grants alternate 0,(blocked)… and only requesters 0 and 1 win until 0 drops.
- Requester 2 sends op=7 → `alu_valid_i=0` that cycle; in cycle 2, `resp_valid[2]=1`, `resp_err=1`, `resp_f=0`.
- Requester 0 sends op=5, a=1, b=31, and holds valid with a new op=6, a=32'h8000_0000, b=31 → first response `32'h8000_0000` in cycle 2, with the second request accepted in that same cycle; second response `1` in cycle 4.
- Two requests are in flight, then `rst` is pulsed for one cycle mid-flight → no `resp_valid` after reset despite the ALU's `alu_valid_o`; `busy` is clear, so the next request is accepted immediately.
